bus_master_req: RTL
===================

# bus_master_req

Requester-side bus interface that pairs with the two-master bus arbiter: one instance sits in front of each master. It buffers up to DEPTH queued bus commands and requests the bus with `m_req`. Once `m_grant` is returned, it issues the queued commands one beat per cycle. It then releases the bus, either when its queue drains or when its tenure limit is reached.

## Interface
- `AW`, 8, address width
- `DW`, 32, data width
- `DEPTH`, 4, command FIFO depth (power of 2, ≥2)
- `MAX_HOLD`, 4, max beats issued per grant tenure (≥1)

Ports:
- `clk` in 1: single clock, all state on rising edge
- `reset_n` in 1: asynchronous, active-low reset
- `cmd_valid` in 1: command push request
- `cmd_we` in 1: 1 = write, 0 = read
- `cmd_addr` in AW: command address
- `cmd_wdata` in DW: write data (ignored for reads)
- `cmd_ready` out 1: FIFO not full; push occurs when `cmd_valid && cmd_ready`
- `m_req` out 1: bus request to arbiter
- `m_grant` in 1: grant from arbiter
- `m_cmd` out 1: bus beat valid this cycle
- `m_wr` out 1: beat is a write
- `m_addr` out AW: beat address
- `m_dout` out DW: beat write data
- `m_din` in DW: read data from bus, valid the cycle after a read beat
- `rsp_valid` out 1: one-cycle pulse, read data returned
- `rsp_rdata` out DW: read data; holds until the next response
- `busy` out 1: FIFO non-empty or state ≠ IDLE

## Operation
- FIFO: DEPTH entries of {we, addr, wdata}. Pointers wrap modulo DEPTH, plus a count of width log2(DEPTH)+1.
  - `cmd_ready = (count != DEPTH)`.
  - A push while full is not possible; `cmd_valid` with `cmd_ready` low is ignored, with no overwrite.
  - Simultaneous push and pop in one cycle leaves count unchanged.
- State machine states: IDLE, REQ, BUS, REL.
  - IDLE: `m_req`=0. If count≠0, go to REQ.
  - REQ: `m_req`=1. When `m_grant`=1 is sampled, go to BUS and clear the beat counter.
  - BUS: `m_req`=1. On each edge where `m_grant`=1 and count≠0, pop the head, register it onto `m_cmd`/`m_wr`/`m_addr`/`m_dout`, and increment the beat counter.
    - If `m_grant`=0 is sampled, issue no beat and go to REQ if count≠0, else REL.
    - If count=0, go to REL.
    - If the beat counter reaches MAX_HOLD, go to REL even if count≠0.
  - REL: `m_req`=0 and `m_cmd`=0 for exactly one cycle, then go to IDLE.
- `m_grant` is ignored whenever `m_req`=0. No beat is issued outside BUS.
- Read return: for a read beat on bus cycle t, `m_din` is sampled at the end of cycle t+1. `rsp_valid`=1 in cycle t+2, with `rsp_rdata`=sampled value.
  - Back-to-back reads give back-to-back `rsp_valid` pulses.
- Reset (async assert, any state): FIFO emptied; state IDLE; beat counter 0. Any pending read response is dropped.
  - All registered outputs are 0: `m_req`, `m_cmd`, `m_wr`, `m_addr`, `m_dout`, `rsp_valid`, `rsp_rdata`.
  - `busy`=0 and `cmd_ready`=1 during and after reset.

## Timing
- All outputs except `cmd_ready` and `busy` are registered.
- Push at edge k puts `m_req`=1 after edge k+1.
- Grant sampled at edge g produces the first `m_cmd`=1 after edge g+1. Beats follow one per cycle while grant holds.
- `m_cmd` is deasserted in the cycle after the last pop, and in the cycle after `m_grant` is seen low.
- `m_req` falls one cycle after the last beat (REL). The minimum gap before re-request is 1 cycle low.
- Grant latency from the arbiter is unbounded; the block waits in REQ indefinitely.

## Test plan
- Reset mid-BUS with 3 entries queued → next cycle `m_req`=0, `m_cmd`=0, `cmd_ready`=1, `busy`=0; no later beats issued.
- Push 2 writes (addr 0x10/0x11, data 0xA5A5_0001/0xA5A5_0002), grant after 3 cycles → exactly 2 consecutive `m_cmd` beats with those values, then `m_req` low for ≥1 cycle, then IDLE.
- Fill FIFO with 4 entries, push a 5th while full → `cmd_ready`=0, the 5th is not stored; exactly 4 beats are issued.
- MAX_HOLD=4, 6 entries pushed over time, grant held → 4 beats, `m_req` low 1 cycle, re-request, remaining 2 beats after the next grant.
- Grant dropped after 1 beat of 3 → no `m_cmd` while grant is low, `m_req` stays 1, remaining 2 beats issue after the grant returns.
- Read of addr 0x20, bus drives `m_din`=0xDEADBEEF in cycle t+1 → `rsp_valid` pulse in t+2 with `rsp_rdata`=0xDEADBEEF, held afterward.

Source files
------------

// File: rtl/bus_master_req_if.sv
// Requester-side bus bundle: command push port, arbitrated bus beat port and read response.
interface bus_master_req_if #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 32
);
  logic          cmd_valid;
  logic          cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          cmd_ready;
  logic          m_req;
  logic          m_grant;
  logic          m_cmd;
  logic          m_wr;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_dout;
  logic [DW-1:0] m_din;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          busy;

  modport master (
    input  cmd_valid, cmd_we, cmd_addr, cmd_wdata, m_grant, m_din,
    output cmd_ready, m_req, m_cmd, m_wr, m_addr, m_dout, rsp_valid, rsp_rdata, busy
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_addr, cmd_wdata, m_grant, m_din,
    input  cmd_ready, m_req, m_cmd, m_wr, m_addr, m_dout, rsp_valid, rsp_rdata, busy
  );
endinterface

// File: rtl/bus_master_req.sv
// Per-master bus requester: queues commands, requests the arbiter, issues one beat per
// granted cycle up to a tenure limit, and returns read data two cycles after a read beat.
module bus_master_req #(
  parameter int unsigned AW       = 8,
  parameter int unsigned DW       = 32,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  bus_master_req_if.master  bus
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned BW = $clog2(MAX_HOLD + 1);

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, REQ, BUS, REL} state_t;

  cmd_t          mem [DEPTH];
  cmd_t          head;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          not_full;
  logic          push_c;
  logic          pop_c;
  logic          beat_clr_c;
  logic          req_nxt_c;
  logic [BW-1:0] beat_cnt;
  state_t        state;
  state_t        state_nxt;

  logic          m_req_q;
  logic          m_cmd_q;
  logic          m_wr_q;
  logic [AW-1:0] m_addr_q;
  logic [DW-1:0] m_dout_q;
  logic          rd_pend;
  logic          rsp_valid_q;
  logic [DW-1:0] rsp_rdata_q;

  assign not_full = (count != CW'(DEPTH));
  assign push_c   = bus.cmd_valid && not_full;
  assign head     = mem[rd_ptr];

  assign bus.cmd_ready = not_full;
  assign bus.busy      = (count != '0) || (state != IDLE);
  assign bus.m_req     = m_req_q;
  assign bus.m_cmd     = m_cmd_q;
  assign bus.m_wr      = m_wr_q;
  assign bus.m_addr    = m_addr_q;
  assign bus.m_dout    = m_dout_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;

  // Command storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem[wr_ptr] <= '{we: bus.cmd_we, addr: bus.cmd_addr, wdata: bus.cmd_wdata};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + PW'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PW'(1);
      case ({push_c, pop_c})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Tenure control: beats only pop on granted BUS cycles with work queued and budget left.
  always_comb begin
    state_nxt  = state;
    pop_c      = 1'b0;
    beat_clr_c = 1'b0;
    case (state)
      IDLE: if (count != '0) state_nxt = REQ;
      REQ: begin
        if (bus.m_grant) begin
          state_nxt  = BUS;
          beat_clr_c = 1'b1;
        end
      end
      BUS: begin
        if (!bus.m_grant) begin
          state_nxt = (count != '0) ? REQ : REL;
        end else if ((count == '0) || (beat_cnt == BW'(MAX_HOLD))) begin
          state_nxt = REL;
        end else begin
          pop_c = 1'b1;
        end
      end
      REL: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    req_nxt_c = (state_nxt == REQ) || (state_nxt == BUS);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_req_q     <= 1'b0;
      m_cmd_q     <= 1'b0;
      m_wr_q      <= 1'b0;
      m_addr_q    <= '0;
      m_dout_q    <= '0;
      beat_cnt    <= '0;
      rd_pend     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      m_req_q <= req_nxt_c;
      m_cmd_q <= pop_c;
      if (pop_c) begin
        m_wr_q   <= head.we;
        m_addr_q <= head.addr;
        m_dout_q <= head.wdata;
      end
      if (beat_clr_c)  beat_cnt <= '0;
      else if (pop_c)  beat_cnt <= beat_cnt + BW'(1);
      // Read data arrives the cycle after the beat and is presented one cycle later.
      rd_pend     <= m_cmd_q && !m_wr_q;
      rsp_valid_q <= rd_pend;
      if (rd_pend) rsp_rdata_q <= bus.m_din;
    end
  end

endmodule
